// File: rtl/cla_sub_pkg.sv
// Shared definitions for the digit-serial CLA subtractor: digit width, FSM
// state encoding and a digit-count helper.
package cla_sub_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sub_state_t;

  function automatic int digit_count(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/cla_digit_2b.sv
// Combinational 2-bit carry-lookahead digit slice. It is driven with
// p = a ^ ~b and g = a & ~b, so the sum is the digit of a - b.
module cla_digit_2b (
  input  logic [1:0] p,
  input  logic [1:0] g,
  input  logic       cin,
  output logic [1:0] s,
  output logic       c_mid,
  output logic       cout,
  output logic       P,
  output logic       G
);

  assign P     = p[1] & p[0];
  assign G     = g[1] | (p[1] & g[0]);
  assign c_mid = g[0] | (p[0] & cin);
  assign cout  = G | (P & cin);
  assign s     = {p[1] ^ c_mid, p[0] ^ cin};

endmodule

// File: rtl/cla_serial_sub.sv
// Digit-serial A - B, two bits per clock through one reused CLA digit slice.
// Optional signed-overflow output enabled by macro CLA_SUB_OVF_EN.
module cla_serial_sub
  import cla_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = digit_count(WIDTH);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  sub_state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_a, r_nb, r_diff;
  logic               r_carry, r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] w_p, w_g, w_s;
  logic               w_cmid, w_cout, w_grp_p, w_grp_g, w_last;
  logic               w_unused;

  assign w_last = (r_cnt == CNT_W'(N - 1));
  assign w_p    = r_a[DIGIT_W*r_cnt +: DIGIT_W] ^ r_nb[DIGIT_W*r_cnt +: DIGIT_W];
  assign w_g    = r_a[DIGIT_W*r_cnt +: DIGIT_W] & r_nb[DIGIT_W*r_cnt +: DIGIT_W];

  cla_digit_2b u_digit (
    .p     (w_p),
    .g     (w_g),
    .cin   (r_carry),
    .s     (w_s),
    .c_mid (w_cmid),
    .cout  (w_cout),
    .P     (w_grp_p),
    .G     (w_grp_g)
  );

  // Group propagate/generate are for cascading slices; a single serial slice needs only cout.
  assign w_unused = w_grp_p ^ w_grp_g ^ w_cmid;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef CLA_SUB_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
`ifdef CLA_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_nb    <= ~b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_diff[DIGIT_W*r_cnt +: DIGIT_W] <= w_s;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_borrow <= ~w_cout;
`ifdef CLA_SUB_OVF_EN
            r_ovf    <= w_cmid ^ w_cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef CLA_SUB_OVF_EN
  assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_cla_serial_sub.sv
// Directed bench for cla_serial_sub (WIDTH = 16); overflow checks are built
// in when CLA_SUB_OVF_EN is defined.
module tb_cla_serial_sub;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready, out_valid, borrow;
  logic [WIDTH-1:0] diff;
`ifdef CLA_SUB_OVF_EN
  logic             ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int edges;

  cla_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef CLA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands and returns one step after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op);
    int t;
    t = 0;
    a = ta;
    b = tb_op;
    in_valid = 1'b1;
    while (!in_ready && t < 40) begin
      step();
      t++;
    end
    chk("accept_wait", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("done_wait", out_valid, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b);
    int n;
    out_ready = 1'b1;
    accept(ta, tb_op);
    wait_done(n);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_borrow"}, borrow, exp_b);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_borrow", borrow, 1'b0);
`ifdef CLA_SUB_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;
    step();

    // Basic subtract with latency measurement: 8 edges after the accepting edge
    accept(16'h1234, 16'h0234);
    chk("basic_run_in_ready", in_ready, 1'b0);
    wait_done(edges);
    chk("basic_latency", edges, 8);
    chk("basic_diff", diff, 16'h1000);
    chk("basic_borrow", borrow, 1'b0);
    step();
    chk("basic_retire_out_valid", out_valid, 1'b0);
    chk("basic_retire_in_ready", in_ready, 1'b1);

    // Unsigned underflow
    run_op("under", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
`ifdef CLA_SUB_OVF_EN
    chk("under_ovf", ovf, 1'b0);
`endif
    step();

`ifdef CLA_SUB_OVF_EN
    run_op("sovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
    chk("sovf_ovf", ovf, 1'b1);
    step();
`endif

    // 0x7FFF - 0xFFFF: unsigned borrow, and signed 32767 - (-1) overflows
    run_op("maxneg", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1);
`ifdef CLA_SUB_OVF_EN
    chk("maxneg_ovf", ovf, 1'b1);
`endif
    step();

    // Backpressure: hold DONE for 5 cycles
    out_ready = 1'b0;
    accept(16'h00FF, 16'h00FF);
    wait_done(edges);
    for (int i = 0; i < 5; i++) begin
      chk("bp_diff", diff, 16'h0000);
      chk("bp_borrow", borrow, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_last_diff", diff, 16'h0000);
    step();
    chk("bp_after_in_ready", in_ready, 1'b1);
    chk("bp_after_out_valid", out_valid, 1'b0);

    // Ignored input: new operands held valid through RUN and DONE
    accept(16'h5555, 16'h1111);
    a = 16'h0003;
    b = 16'h0005;
    in_valid = 1'b1;
    wait_done(edges);
    chk("ign_first_diff", diff, 16'h4444);
    chk("ign_first_borrow", borrow, 1'b0);
    step();
    chk("ign_idle_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ign_accepted", in_ready, 1'b0);
    wait_done(edges);
    chk("ign_second_latency", edges, 8);
    chk("ign_second_diff", diff, 16'hFFFE);
    chk("ign_second_borrow", borrow, 1'b1);
    step();

    // Reset during RUN cycle 3
    accept(16'h1234, 16'h0001);
    step();
    step();
    chk("mid_in_run", in_ready, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_diff", diff, 16'h0000);
    chk("mid_rst_borrow", borrow, 1'b0);
    step();
    chk("mid_rst_stays_idle", out_valid, 1'b0);
    run_op("fresh", 16'h00F0, 16'h000F, 16'h00E1, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
